// File: rtl/wb_arbiter.sv
// Two-master round-robin arbiter in front of one pipelined Wishbone slave.
// Only grant bookkeeping is registered; every bus path is a mux on the grant.
module wb_arbiter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic        m0_ack_o,
  output logic        m0_stall_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic        m1_ack_o,
  output logic        m1_stall_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic        s_ack_i,
  input  logic        s_stall_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_lg;
  logic [3:0]  r_outst;
  logic [3:0]  r_drop;

  logic        w_own_cyc;
  logic        w_abort;
  logic        w_accept;
  logic        w_ack_route;
  logic        w_ack_disc;
  logic [3:0]  w_pend;

  assign w_own_cyc = (r_state == ST_GNT0) ? m0_cyc_i :
                     ((r_state == ST_GNT1) ? m1_cyc_i : 1'b0);
  assign w_abort   = ((r_state == ST_GNT0) && !m0_cyc_i) ||
                     ((r_state == ST_GNT1) && !m1_cyc_i);
  assign w_accept  = s_cyc_o & s_stb_o & ~s_stall_i;

  // Acks owed to an aborted cycle are swallowed until the slave has returned them all.
  assign w_ack_route = s_ack_i & w_own_cyc & (r_drop == 4'd0);
  assign w_pend      = r_drop + (w_abort ? r_outst : 4'd0);
  assign w_ack_disc  = s_ack_i & ~w_ack_route & (w_pend != 4'd0);

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Grant FSM, last-grant pointer and outstanding/discard bookkeeping.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_lg    <= 1'b1;
      r_outst <= 4'd0;
      r_drop  <= 4'd0;
    end else begin
      r_drop <= w_pend - {3'd0, w_ack_disc};
      case (r_state)
        ST_IDLE: begin
          r_outst <= 4'd0;
          if (m0_cyc_i && m1_cyc_i) begin
            r_state <= r_lg ? ST_GNT0 : ST_GNT1;
          end else if (m0_cyc_i) begin
            r_state <= ST_GNT0;
          end else if (m1_cyc_i) begin
            r_state <= ST_GNT1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_GNT0: begin
          if (m0_cyc_i) begin
            r_outst <= r_outst + {3'd0, w_accept} - {3'd0, w_ack_route};
          end else begin
            r_outst <= 4'd0;
            r_lg    <= 1'b0;
            r_state <= m1_cyc_i ? ST_GNT1 : ST_IDLE;
          end
        end
        ST_GNT1: begin
          if (m1_cyc_i) begin
            r_outst <= r_outst + {3'd0, w_accept} - {3'd0, w_ack_route};
          end else begin
            r_outst <= 4'd0;
            r_lg    <= 1'b1;
            r_state <= m0_cyc_i ? ST_GNT0 : ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_outst <= 4'd0;
        end
      endcase
    end
  end

  // Bus muxes: the granted master sees the slave, everyone else is held off.
  always_comb begin
    s_adr_o    = 32'd0;
    s_dat_o    = 32'd0;
    s_we_o     = 1'b0;
    s_sel_o    = 4'd0;
    s_stb_o    = 1'b0;
    s_cyc_o    = 1'b0;
    m0_ack_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m0_stall_o = 1'b1;
    m1_stall_o = 1'b1;
    case (r_state)
      ST_GNT0: begin
        s_adr_o    = m0_adr_i;
        s_dat_o    = m0_dat_i;
        s_we_o     = m0_we_i;
        s_sel_o    = m0_sel_i;
        s_stb_o    = m0_stb_i;
        s_cyc_o    = m0_cyc_i;
        m0_ack_o   = w_ack_route;
        m0_stall_o = s_stall_i;
      end
      ST_GNT1: begin
        s_adr_o    = m1_adr_i;
        s_dat_o    = m1_dat_i;
        s_we_o     = m1_we_i;
        s_sel_o    = m1_sel_i;
        s_stb_o    = m1_stb_i;
        s_cyc_o    = m1_cyc_i;
        m1_ack_o   = w_ack_route;
        m1_stall_o = s_stall_i;
      end
      default: begin
        s_cyc_o = 1'b0;
      end
    endcase
  end

endmodule
